// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param
// Sequence-memory game controller with a parametrised number of buttons,
// sequence depth, display time and play timeout.
//
// Round r shows memory elements 0..r on leds. Each element is lit for
// MOSTRA_CICLOS cycles and followed by a dark gap of the same length. The
// player then has to repeat elements 0..r on the buttons. While modo=1 each
// play must arrive within TIMEOUT_CICLOS cycles.
//
// Ports
//   clock, reset       system clock, asynchronous active-high reset
//   jogar              start/restart request (honoured in inicial and fim states)
//   botoes             synchronised button levels
//   modo               1 = play timeout enabled, 0 = unlimited time
//   mem_endereco       address to the external sequence memory
//   mem_dado           memory data, combinational w.r.t. mem_endereco
//   leds               shown element (mostra) or button echo (espera)
//   pronto/ganhou/perdeu/timeout   game result flags
//   db_estado          state code
//   db_rodada          current round limit
//   db_contagem        current address
//   db_jogada          last registered play
//
// state        | code | meaning
// inicial      |  0   | idle after reset, waits for jogar
// preparacao   |  1   | clears round limit, address and timers
// mostra       |  2   | element at endereco lit on leds
// intervalo    |  3   | dark gap after an element
// espera       |  4   | waits for a play (optionally with timeout)
// compara      |  5   | checks the registered play against memory
// fim_acertou  |  6   | whole sequence reproduced
// fim_errou    |  7   | wrong play
// fim_timeout  |  8   | no play in time
module jogo_memoria_param #(
  parameter int N_BOTOES       = 4,
  parameter int PROFUNDIDADE   = 16,
  parameter int MOSTRA_CICLOS  = 1000,
  parameter int TIMEOUT_CICLOS = 5000,
  localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                modo,
  output logic [AW-1:0]       mem_endereco,
  input  logic [N_BOTOES-1:0] mem_dado,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic [3:0]          db_estado,
  output logic [AW-1:0]       db_rodada,
  output logic [AW-1:0]       db_contagem,
  output logic [N_BOTOES-1:0] db_jogada
);

  localparam int MW = (MOSTRA_CICLOS > 1) ? $clog2(MOSTRA_CICLOS) : 1;
  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

  // Both timers count down from their load value; reaching zero marks the
  // last cycle of the interval.
  localparam logic [MW-1:0] MOSTRA_CARGA  = MW'(MOSTRA_CICLOS - 1);
  localparam logic [TW-1:0] TIMEOUT_CARGA = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [AW-1:0] ULTIMO        = AW'(PROFUNDIDADE - 1);

  localparam logic [3:0] INICIAL     = 4'd0;
  localparam logic [3:0] PREPARACAO  = 4'd1;
  localparam logic [3:0] MOSTRA      = 4'd2;
  localparam logic [3:0] INTERVALO   = 4'd3;
  localparam logic [3:0] ESPERA      = 4'd4;
  localparam logic [3:0] COMPARA     = 4'd5;
  localparam logic [3:0] FIM_ACERTOU = 4'd6;
  localparam logic [3:0] FIM_ERROU   = 4'd7;
  localparam logic [3:0] FIM_TIMEOUT = 4'd8;

  logic [3:0]          estado_q, estado_d;
  logic [AW-1:0]       limite_q, limite_d;
  logic [AW-1:0]       endereco_q, endereco_d;
  logic [MW-1:0]       mostra_cnt_q, mostra_cnt_d;
  logic [TW-1:0]       timeout_cnt_q, timeout_cnt_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic [N_BOTOES-1:0] botoes_prev_q;
  logic                jogada_feita;

  // A play is a transition from all-released to any button pressed. A press
  // that began before espera therefore never counts, even if still held.
  assign jogada_feita = (|botoes) & ~(|botoes_prev_q);

  always_comb begin
    estado_d      = estado_q;
    limite_d      = limite_q;
    endereco_d    = endereco_q;
    mostra_cnt_d  = mostra_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    jogada_d      = jogada_q;

    case (estado_q)
      INICIAL: begin
        if (jogar) estado_d = PREPARACAO;
      end

      PREPARACAO: begin
        limite_d      = '0;
        endereco_d    = '0;
        mostra_cnt_d  = MOSTRA_CARGA;
        timeout_cnt_d = TIMEOUT_CARGA;
        estado_d      = MOSTRA;
      end

      MOSTRA: begin
        if (mostra_cnt_q == '0) begin
          mostra_cnt_d = MOSTRA_CARGA;
          estado_d     = INTERVALO;
        end else begin
          mostra_cnt_d = mostra_cnt_q - 1'b1;
        end
      end

      INTERVALO: begin
        if (mostra_cnt_q == '0) begin
          mostra_cnt_d = MOSTRA_CARGA;
          if (endereco_q < limite_q) begin
            endereco_d = endereco_q + 1'b1;
            estado_d   = MOSTRA;
          end else begin
            endereco_d    = '0;
            timeout_cnt_d = TIMEOUT_CARGA;
            estado_d      = ESPERA;
          end
        end else begin
          mostra_cnt_d = mostra_cnt_q - 1'b1;
        end
      end

      ESPERA: begin
        // A play on the expiry cycle takes priority over the timeout.
        if (jogada_feita) begin
          jogada_d = botoes;
          estado_d = COMPARA;
        end else if (modo) begin
          if (timeout_cnt_q == '0) estado_d = FIM_TIMEOUT;
          else                     timeout_cnt_d = timeout_cnt_q - 1'b1;
        end
      end

      COMPARA: begin
        if (jogada_q != mem_dado) begin
          estado_d = FIM_ERROU;
        end else if (endereco_q < limite_q) begin
          endereco_d    = endereco_q + 1'b1;
          timeout_cnt_d = TIMEOUT_CARGA;
          estado_d      = ESPERA;
        end else if (limite_q < ULTIMO) begin
          limite_d     = limite_q + 1'b1;
          endereco_d   = '0;
          mostra_cnt_d = MOSTRA_CARGA;
          estado_d     = MOSTRA;
        end else begin
          estado_d = FIM_ACERTOU;
        end
      end

      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (jogar) estado_d = PREPARACAO;
      end

      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q      <= INICIAL;
      limite_q      <= '0;
      endereco_q    <= '0;
      mostra_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      jogada_q      <= '0;
      botoes_prev_q <= '0;
    end else begin
      estado_q      <= estado_d;
      limite_q      <= limite_d;
      endereco_q    <= endereco_d;
      mostra_cnt_q  <= mostra_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      jogada_q      <= jogada_d;
      botoes_prev_q <= botoes;
    end
  end

  // Outputs decode straight from the state register so an asynchronous
  // reset clears them without waiting for a clock edge.
  always_comb begin
    leds    = '0;
    pronto  = 1'b0;
    ganhou  = 1'b0;
    perdeu  = 1'b0;
    timeout = 1'b0;
    case (estado_q)
      MOSTRA:      leds = mem_dado;
      ESPERA:      leds = botoes;
      FIM_ACERTOU: begin pronto = 1'b1; ganhou = 1'b1; end
      FIM_ERROU:   begin pronto = 1'b1; perdeu = 1'b1; end
      FIM_TIMEOUT: begin pronto = 1'b1; perdeu = 1'b1; timeout = 1'b1; end
      default:     leds = '0;
    endcase
  end

  assign mem_endereco = endereco_q;
  assign db_estado    = estado_q;
  assign db_rodada    = limite_q;
  assign db_contagem  = endereco_q;
  assign db_jogada    = jogada_q;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// tb_jogo_memoria_param
// Self-checking bench for jogo_memoria_param with 4 buttons, depth 4,
// 2-cycle display and 8-cycle timeout. The expected behaviour of each game
// is derived from the game rules: the per-round display sequence, the play
// outcome and the timeout window are computed from the memory contents held
// in the bench.
module tb_jogo_memoria_param;

  localparam int N = 4;
  localparam int P = 4;
  localparam int M = 2;
  localparam int T = 8;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          jogar;
  logic [N-1:0]  botoes;
  logic          modo;
  logic [AW-1:0] mem_endereco;
  logic [N-1:0]  mem_dado;
  logic [N-1:0]  leds;
  logic          pronto, ganhou, perdeu, timeout;
  logic [3:0]    db_estado;
  logic [AW-1:0] db_rodada, db_contagem;
  logic [N-1:0]  db_jogada;

  logic [N-1:0]  mem [P];

  int n_checks = 0;
  int n_fail   = 0;

  assign mem_dado = mem[mem_endereco];

  jogo_memoria_param #(
    .N_BOTOES(N), .PROFUNDIDADE(P), .MOSTRA_CICLOS(M), .TIMEOUT_CICLOS(T)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .modo(modo),
    .mem_endereco(mem_endereco), .mem_dado(mem_dado), .leds(leds),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .db_estado(db_estado), .db_rodada(db_rodada), .db_contagem(db_contagem),
    .db_jogada(db_jogada)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic p, input logic g,
                           input logic l, input logic t);
    chk({tag, "_pronto"},  32'(pronto),  32'(p));
    chk({tag, "_ganhou"},  32'(ganhou),  32'(g));
    chk({tag, "_perdeu"},  32'(perdeu),  32'(l));
    chk({tag, "_timeout"}, 32'(timeout), 32'(t));
  endtask

  function automatic logic [N-1:0] wrong_val(input logic [N-1:0] right);
    logic [N-1:0] v;
    v = N'($urandom_range(1, 15));
    while (v == right) v = N'($urandom_range(1, 15));
    return v;
  endfunction

  // Pulse jogar from inicial or a fim state; leaves the bench at the first
  // display cycle of round 0.
  task automatic start_game();
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    chk("prep_estado", 32'(db_estado), 32'd1);
    chk_flags("prep", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("prep_leds", 32'(leds), 32'd0);
    step();
  endtask

  // Round r: elements 0..r, each lit M cycles then dark M cycles; ends at the
  // first espera cycle.
  task automatic show_round(input int r);
    for (int e = 0; e <= r; e++) begin
      for (int k = 0; k < M; k++) begin
        chk("mostra_estado", 32'(db_estado), 32'd2);
        chk("mostra_leds", 32'(leds), 32'(mem[e]));
        chk("mostra_end", 32'(mem_endereco), 32'(e));
        chk("mostra_rodada", 32'(db_rodada), 32'(r));
        step();
      end
      for (int k = 0; k < M; k++) begin
        chk("interv_estado", 32'(db_estado), 32'd3);
        chk("interv_leds", 32'(leds), 32'd0);
        step();
      end
    end
    chk("espera_estado", 32'(db_estado), 32'd4);
    chk("espera_cont", 32'(db_contagem), 32'd0);
    chk("espera_leds", 32'(leds), 32'(botoes));
  endtask

  // Idle w cycles in espera, then press v for one cycle; ends on the cycle
  // after compara.
  task automatic press(input logic [N-1:0] v, input int w);
    for (int i = 0; i < w; i++) begin
      chk("espera_idle", 32'(db_estado), 32'd4);
      step();
    end
    botoes = v;
    #1;
    chk("echo_leds", 32'(leds), 32'(v));
    step();
    chk("compara_estado", 32'(db_estado), 32'd5);
    chk("compara_jogada", 32'(db_jogada), 32'(v));
    botoes = '0;
    step();
  endtask

  task automatic run_game(input bit md, input int err_pct);
    int a, w, fim;
    logic [N-1:0] v;
    modo = md;
    fim  = 0;
    start_game();
    for (int r = 0; r < P && fim == 0; r++) begin
      show_round(r);
      for (int e = 0; e <= r && fim == 0; e++) begin
        a = $urandom_range(0, 99);
        if (md && a < err_pct) begin
          for (int i = 0; i < T; i++) begin
            chk("tmo_wait", 32'(db_estado), 32'd4);
            step();
          end
          chk("tmo_estado", 32'(db_estado), 32'd8);
          chk_flags("tmo", 1'b1, 1'b0, 1'b1, 1'b1);
          chk("tmo_leds", 32'(leds), 32'd0);
          fim = 8;
        end else begin
          w = md ? $urandom_range(0, T - 1) : $urandom_range(0, 12);
          v = (a < 2 * err_pct) ? wrong_val(mem[e]) : mem[e];
          press(v, w);
          if (v != mem[e]) begin
            chk("errou_estado", 32'(db_estado), 32'd7);
            chk_flags("errou", 1'b1, 1'b0, 1'b1, 1'b0);
            fim = 7;
          end else if (e < r) begin
            chk("next_estado", 32'(db_estado), 32'd4);
            chk("next_cont", 32'(db_contagem), 32'(e + 1));
          end else if (r == P - 1) begin
            chk("ganhou_estado", 32'(db_estado), 32'd6);
            chk_flags("ganhou", 1'b1, 1'b1, 1'b0, 1'b0);
            chk("ganhou_leds", 32'(leds), 32'd0);
            fim = 6;
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fim_hold", 32'(db_estado), 32'(fim));
    end
  endtask

  initial begin
    reset  = 1'b1;
    jogar  = 1'b0;
    botoes = '0;
    modo   = 1'b0;
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
    #2;
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_leds", 32'(leds), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("idle_estado", 32'(db_estado), 32'd0);

    // Full win without timeout.
    run_game(1'b0, 0);

    // Wrong play in round 1: 1 then 4.
    modo = 1'b0;
    start_game();
    show_round(0);
    press(4'd1, 0);
    show_round(1);
    press(4'd1, 1);
    chk("w_next", 32'(db_estado), 32'd4);
    press(4'd4, 0);
    chk("w_estado", 32'(db_estado), 32'd7);
    chk_flags("w", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("w_jogada", 32'(db_jogada), 32'd4);

    // Timeout with modo=1: exactly T espera cycles.
    modo = 1'b1;
    start_game();
    show_round(0);
    for (int i = 0; i < T; i++) begin
      chk("t_wait", 32'(db_estado), 32'd4);
      step();
    end
    chk("t_estado", 32'(db_estado), 32'd8);
    chk_flags("t", 1'b1, 1'b0, 1'b1, 1'b1);

    // modo=0: no timeout over 50 idle cycles.
    modo = 1'b0;
    start_game();
    show_round(0);
    for (int i = 0; i < 50; i++) step();
    chk("nt_estado", 32'(db_estado), 32'd4);
    press(4'd1, 0);

    // Asynchronous reset while round 1 is on display.
    chk("ar_pre", 32'(db_estado), 32'd2);
    #3 reset = 1'b1;
    #1;
    chk("ar_estado", 32'(db_estado), 32'd0);
    chk("ar_leds", 32'(leds), 32'd0);
    chk("ar_rodada", 32'(db_rodada), 32'd0);
    chk("ar_end", 32'(mem_endereco), 32'd0);
    chk("ar_jogada", 32'(db_jogada), 32'd0);
    #2 reset = 1'b0;
    step();
    chk("ar_idle", 32'(db_estado), 32'd0);
    start_game();
    show_round(0);
    press(4'd1, 0);
    show_round(1);

    // jogar in espera is ignored; a press held from the display is not a play.
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    step();
    chk("jg_estado", 32'(db_estado), 32'd4);
    chk("jg_rodada", 32'(db_rodada), 32'd1);
    press(4'd1, 0);
    chk("jg_next", 32'(db_estado), 32'd4);
    press(4'd2, 0);
    botoes = 4'd1;
    show_round(2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_estado", 32'(db_estado), 32'd4);
    end
    botoes = '0;
    step();
    // Play on the expiry cycle beats the timeout.
    modo = 1'b1;
    press(4'd1, T - 1);
    chk("edge_next", 32'(db_estado), 32'd4);
    // Multi-bit 0011 against data 0010 is a wrong play.
    press(4'b0011, 0);
    chk("mb_estado", 32'(db_estado), 32'd7);
    chk("mb_jogada", 32'(db_jogada), 32'd3);

    // Randomised games with random memory and mode, restarted from fim states.
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < P; i++) mem[i] = N'($urandom_range(1, 15));
      run_game(1'($urandom_range(0, 1)), 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
